// File: rtl/bp_pkg.sv
// Shared definitions for the set-associative branch target buffer:
// direction-counter encodings and geometry helpers.
package bp_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } dir_ctr_e;

  // Freshly allocated entries start weakly taken.
  localparam dir_ctr_e ALLOC_CTR = WEAK_T;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int xlen, input int sets);
    return xlen - $clog2(sets) - 2;
  endfunction

  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-value logic for a saturating up/down counter; the caller owns the register.
// UP_ONLY=1 ignores i_down, used for the performance counters.
module bp_sat_counter #(
  parameter int W       = 2,
  parameter bit UP_ONLY = 1'b0
) (
  input  logic [W-1:0] i_count,
  input  logic         i_up,
  input  logic         i_down,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] MAX_VAL = '1;

  logic w_down;

  assign w_down = UP_ONLY ? 1'b0 : i_down;

  always_comb begin
    o_count = i_count;
    if (i_up && !w_down) begin
      if (i_count != MAX_VAL) o_count = i_count + W'(1);
    end else if (w_down && !i_up) begin
      if (i_count != '0) o_count = i_count - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Set-associative BTB with 2-bit direction counters, round-robin replacement,
// invalidate-all and saturating update/mispredict counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SETS  = 16,
  parameter int WAYS  = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             predicted,
  output logic [XLEN-1:0]  predicted_address,
  output logic             lookup_hit,
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic [XLEN-1:0]  upd_target,
  input  logic             upd_taken,
  input  logic             upd_is_jump,
  input  logic             upd_pred_taken,
  input  logic [XLEN-1:0]  upd_pred_target,
  input  logic             invalidate,
  output logic [CNT_W-1:0] update_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(XLEN, SETS);
  localparam int WAY_W = way_w(WAYS);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [1:0]       ctr;
    logic             is_jump;
  } entry_t;

  entry_t           r_mem [SETS][WAYS];
  logic [WAY_W-1:0] r_rr  [SETS];
  logic [CNT_W-1:0] r_update_count;
  logic [CNT_W-1:0] r_mispredict_count;

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;
  logic [WAY_W-1:0] w_lk_way;
  logic [XLEN-1:0]  w_lk_target;
  logic [1:0]       w_lk_ctr;
  logic             w_lk_jump;

  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic [WAY_W-1:0] w_up_way;
  logic [1:0]       w_up_ctr;
  logic [1:0]       w_ctr_next;
  logic             w_up_has_inv;
  logic [WAY_W-1:0] w_up_inv_way;
  logic [WAY_W-1:0] w_victim;
  logic [WAY_W-1:0] w_rr_next;
  entry_t           w_alloc_entry;

  logic             w_accept;
  logic             w_mispredict;
  logic [CNT_W-1:0] w_update_count_next;
  logic [CNT_W-1:0] w_mispredict_count_next;
  logic             w_unused_pc_bits;

  assign w_lk_idx = lookup_pc[IDX_W+1:2];
  assign w_lk_tag = lookup_pc[XLEN-1:IDX_W+2];
  assign w_up_idx = upd_pc[IDX_W+1:2];
  assign w_up_tag = upd_pc[XLEN-1:IDX_W+2];
  assign w_unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  // Descending scan so the lowest matching way wins.
  always_comb begin
    w_lk_hit = 1'b0;
    w_lk_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_mem[w_lk_idx][w].valid && (r_mem[w_lk_idx][w].tag == w_lk_tag)) begin
        w_lk_hit = 1'b1;
        w_lk_way = WAY_W'(w);
      end
    end
    w_lk_target = r_mem[w_lk_idx][w_lk_way].target;
    w_lk_ctr    = r_mem[w_lk_idx][w_lk_way].ctr;
    w_lk_jump   = r_mem[w_lk_idx][w_lk_way].is_jump;
  end

  assign lookup_hit        = w_lk_hit;
  assign predicted         = w_lk_hit && (w_lk_jump || w_lk_ctr[1]);
  assign predicted_address = w_lk_hit ? w_lk_target : '0;

  always_comb begin
    w_up_hit     = 1'b0;
    w_up_way     = '0;
    w_up_has_inv = 1'b0;
    w_up_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_mem[w_up_idx][w].valid && (r_mem[w_up_idx][w].tag == w_up_tag)) begin
        w_up_hit = 1'b1;
        w_up_way = WAY_W'(w);
      end
      if (!r_mem[w_up_idx][w].valid) begin
        w_up_has_inv = 1'b1;
        w_up_inv_way = WAY_W'(w);
      end
    end
    w_up_ctr = r_mem[w_up_idx][w_up_way].ctr;
  end

  // Round-robin pointer is consulted, and advanced, only when the set is full.
  assign w_victim  = w_up_has_inv ? w_up_inv_way : r_rr[w_up_idx];
  assign w_rr_next = (r_rr[w_up_idx] == WAY_W'(WAYS - 1)) ? '0 : r_rr[w_up_idx] + WAY_W'(1);

  always_comb begin
    w_alloc_entry         = '0;
    w_alloc_entry.valid   = 1'b1;
    w_alloc_entry.tag     = w_up_tag;
    w_alloc_entry.target  = upd_target;
    w_alloc_entry.ctr     = ALLOC_CTR;
    w_alloc_entry.is_jump = upd_is_jump;
  end

  bp_sat_counter #(.W(2), .UP_ONLY(1'b0)) u_dir_ctr (
    .i_count (w_up_ctr),
    .i_up    (upd_taken),
    .i_down  (!upd_taken),
    .o_count (w_ctr_next)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_rr[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_mem[s][w] <= '0;
      end
    end else if (enable) begin
      if (invalidate) begin
        for (int s = 0; s < SETS; s++) begin
          for (int w = 0; w < WAYS; w++) r_mem[s][w].valid <= 1'b0;
        end
      end else if (upd_valid) begin
        if (w_up_hit) begin
          r_mem[w_up_idx][w_up_way].target  <= upd_target;
          r_mem[w_up_idx][w_up_way].is_jump <= upd_is_jump;
          r_mem[w_up_idx][w_up_way].ctr     <= w_ctr_next;
        end else if (upd_taken) begin
          r_mem[w_up_idx][w_victim] <= w_alloc_entry;
          if (!w_up_has_inv) r_rr[w_up_idx] <= w_rr_next;
        end
      end
    end
  end

  // An update dropped by invalidate or a frozen pipeline is neither counted nor scored.
  assign w_accept     = enable && upd_valid && !invalidate;
  assign w_mispredict = (upd_pred_taken != upd_taken) ||
                        (upd_pred_taken && upd_taken && (upd_pred_target != upd_target));

  bp_sat_counter #(.W(CNT_W), .UP_ONLY(1'b1)) u_update_cnt (
    .i_count (r_update_count),
    .i_up    (w_accept),
    .i_down  (1'b0),
    .o_count (w_update_count_next)
  );

  bp_sat_counter #(.W(CNT_W), .UP_ONLY(1'b1)) u_mispredict_cnt (
    .i_count (r_mispredict_count),
    .i_up    (w_accept && w_mispredict),
    .i_down  (1'b0),
    .o_count (w_mispredict_count_next)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_update_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      r_update_count     <= w_update_count_next;
      r_mispredict_count <= w_mispredict_count_next;
    end
  end

  assign update_count     = r_update_count;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural BTB model.
module tb_branch_predictor;

  localparam int XLEN    = 32;
  localparam int SETS    = 16;
  localparam int WAYS    = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int IDXB    = $clog2(SETS);

  logic             clk;
  logic             rst;
  logic             enable;
  logic [XLEN-1:0]  lookup_pc;
  logic             predicted;
  logic [XLEN-1:0]  predicted_address;
  logic             lookup_hit;
  logic             upd_valid;
  logic [XLEN-1:0]  upd_pc;
  logic [XLEN-1:0]  upd_target;
  logic             upd_taken;
  logic             upd_is_jump;
  logic             upd_pred_taken;
  logic [XLEN-1:0]  upd_pred_target;
  logic             invalidate;
  logic [CNT_W-1:0] update_count;
  logic [CNT_W-1:0] mispredict_count;

  branch_predictor #(.XLEN(XLEN), .SETS(SETS), .WAYS(WAYS), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .lookup_pc         (lookup_pc),
    .predicted         (predicted),
    .predicted_address (predicted_address),
    .lookup_hit        (lookup_hit),
    .upd_valid         (upd_valid),
    .upd_pc            (upd_pc),
    .upd_target        (upd_target),
    .upd_taken         (upd_taken),
    .upd_is_jump       (upd_is_jump),
    .upd_pred_taken    (upd_pred_taken),
    .upd_pred_target   (upd_pred_target),
    .invalidate        (invalidate),
    .update_count      (update_count),
    .mispredict_count  (mispredict_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Behavioural model: a table of entries per set, indexed/tagged arithmetically.
  bit          m_valid  [SETS][WAYS];
  logic [31:0] m_tag    [SETS][WAYS];
  logic [31:0] m_target [SETS][WAYS];
  int          m_ctr    [SETS][WAYS];
  bit          m_jump   [SETS][WAYS];
  int          m_rr     [SETS];
  int          m_upd;
  int          m_mis;

  function automatic int set_of(input logic [31:0] pc);
    return int'((pc >> 2) % SETS);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDXB + 2);
  endfunction

  function automatic int m_find(input logic [31:0] pc);
    int s;
    s = set_of(pc);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == tag_of(pc)) return w;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int s;
    int w;
    int v;
    if (!rst) begin
      for (int i = 0; i < SETS; i++) begin
        m_rr[i] = 0;
        for (int j = 0; j < WAYS; j++) begin
          m_valid[i][j] = 0; m_tag[i][j] = 0; m_target[i][j] = 0;
          m_ctr[i][j] = 0; m_jump[i][j] = 0;
        end
      end
      m_upd = 0;
      m_mis = 0;
    end else if (enable) begin
      if (invalidate) begin
        for (int i = 0; i < SETS; i++)
          for (int j = 0; j < WAYS; j++) m_valid[i][j] = 0;
      end else if (upd_valid) begin
        if (m_upd < CNT_MAX) m_upd++;
        if ((upd_pred_taken != upd_taken) ||
            (upd_pred_taken && upd_taken && upd_pred_target != upd_target))
          if (m_mis < CNT_MAX) m_mis++;
        s = set_of(upd_pc);
        w = m_find(upd_pc);
        if (w >= 0) begin
          m_target[s][w] = upd_target;
          m_jump[s][w]   = upd_is_jump;
          if (upd_taken) m_ctr[s][w] = (m_ctr[s][w] == 3) ? 3 : m_ctr[s][w] + 1;
          else           m_ctr[s][w] = (m_ctr[s][w] == 0) ? 0 : m_ctr[s][w] - 1;
        end else if (upd_taken) begin
          v = -1;
          for (int j = WAYS - 1; j >= 0; j--) if (!m_valid[s][j]) v = j;
          if (v < 0) begin
            v = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % WAYS;
          end
          m_valid[s][v]  = 1;
          m_tag[s][v]    = tag_of(upd_pc);
          m_target[s][v] = upd_target;
          m_ctr[s][v]    = 2;
          m_jump[s][v]   = upd_is_jump;
        end
      end
    end
  end

  // Scoreboard compare, every negedge once the model has seen a reset.
  always @(negedge clk) begin : compare
    int w;
    int s;
    logic        e_hit;
    logic        e_pred;
    logic [31:0] e_addr;
    if (chk_on) begin
      w = m_find(lookup_pc);
      s = set_of(lookup_pc);
      e_hit  = (w >= 0);
      e_pred = e_hit && (m_jump[s][w] || m_ctr[s][w] >= 2);
      e_addr = e_hit ? m_target[s][w] : 32'h0;
      chk("model_hit", {31'b0, lookup_hit}, {31'b0, e_hit});
      chk("model_pred", {31'b0, predicted}, {31'b0, e_pred});
      chk("model_addr", predicted_address, e_addr);
      chk("model_upd_cnt", 32'(update_count), 32'(m_upd));
      chk("model_mis_cnt", 32'(mispredict_count), 32'(m_mis));
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    upd_valid  = 1'b0;
    invalidate = 1'b0;
    enable     = 1'b1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                     input logic jmp, input logic ptk, input logic [31:0] ptgt);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_target      = tgt;
    upd_taken       = tk;
    upd_is_jump     = jmp;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc, input logic h, input logic p, input logic [31:0] a);
    lookup_pc = pc;
    #1;
    chk("lit_hit", {31'b0, lookup_hit}, {31'b0, h});
    chk("lit_pred", {31'b0, predicted}, {31'b0, p});
    chk("lit_addr", predicted_address, a);
    tick();
  endtask

  task automatic counts(input int u, input int m);
    #1;
    chk("lit_upd_cnt", 32'(update_count), 32'(u));
    chk("lit_mis_cnt", 32'(mispredict_count), 32'(m));
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    upd_valid = 1'b1;
    upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h1234;
    tick(); tick();
    rst = 1'b1;
    idle();
  endtask

  initial begin
    rst = 1'b0; enable = 1'b1; invalidate = 1'b0; upd_valid = 1'b0;
    lookup_pc = 0; upd_pc = 0; upd_target = 0; upd_taken = 0; upd_is_jump = 0;
    upd_pred_taken = 0; upd_pred_target = 0;
    tick();
    do_reset();
    chk_on = 1'b1;
    look(32'h40, 0, 0, 0);
    counts(0, 0);

    // Allocate and train
    upd(32'h40, 32'h100, 1, 0, 1, 32'h100);
    look(32'h40, 1, 1, 32'h100);
    upd(32'h40, 32'h100, 0, 0, 0, 32'h100);
    upd(32'h40, 32'h100, 0, 0, 0, 32'h100);
    look(32'h40, 1, 0, 32'h100);
    upd(32'h40, 32'h100, 1, 0, 1, 32'h100);
    look(32'h40, 1, 0, 32'h100);
    counts(4, 0);

    // Invalidate drops the simultaneous update
    invalidate = 1'b1;
    upd(32'h80, 32'h180, 1, 0, 1, 32'h180);
    invalidate = 1'b0;
    look(32'h40, 0, 0, 0);
    look(32'h80, 0, 0, 0);
    counts(4, 0);

    // Replacement in set 0
    upd(32'h40, 32'h140, 1, 0, 1, 32'h140);
    upd(32'h80, 32'h180, 1, 0, 1, 32'h180);
    upd(32'hC0, 32'h1C0, 1, 0, 1, 32'h1C0);
    look(32'h40, 0, 0, 0);
    look(32'h80, 1, 1, 32'h180);
    look(32'hC0, 1, 1, 32'h1C0);
    upd(32'h100, 32'h200, 1, 0, 1, 32'h200);
    look(32'h80, 0, 0, 0);
    look(32'h100, 1, 1, 32'h200);
    look(32'hC0, 1, 1, 32'h1C0);
    counts(8, 0);

    // Jump entries predict taken regardless of the counter
    upd(32'h200, 32'h300, 1, 1, 1, 32'h300);
    for (int i = 0; i < 4; i++) upd(32'h200, 32'h300, 0, 1, 0, 32'h300);
    look(32'h200, 1, 1, 32'h300);
    counts(13, 0);

    // Mispredict accounting and saturation
    upd(32'h400, 32'h500, 0, 0, 1, 32'h500);
    counts(14, 1);
    upd(32'h404, 32'h20, 1, 0, 1, 32'h10);
    counts(15, 2);
    for (int i = 0; i < 20; i++) upd(32'h408, 32'h30, 0, 0, 0, 32'h30);
    counts(15, 2);
    upd(32'h40C, 32'h40, 1, 0, 0, 32'h40);
    counts(15, 3);
    for (int i = 0; i < 14; i++) upd(32'h410, 32'h50, 0, 0, 1, 32'h50);
    counts(15, 15);

    // Frozen pipeline
    enable = 1'b0;
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    upd(32'h800, 32'h900, 1, 0, 0, 32'h0);
    idle();
    look(32'h200, 1, 1, 32'h300);
    look(32'h800, 0, 0, 0);
    look(32'h404, 1, 1, 32'h20);
    counts(15, 15);

    do_reset();
    look(32'h200, 0, 0, 0);
    counts(0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      enable          = ($urandom_range(0, 99) < 90);
      invalidate      = ($urandom_range(0, 99) < 3);
      upd_valid       = ($urandom_range(0, 99) < 60);
      upd_pc          = (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 3)) << 2) |
                        32'($urandom_range(0, 3));
      lookup_pc       = (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 3)) << 2) |
                        32'($urandom_range(0, 3));
      upd_target      = $urandom;
      upd_taken       = $urandom_range(0, 1) == 1;
      upd_is_jump     = ($urandom_range(0, 99) < 20);
      upd_pred_taken  = $urandom_range(0, 1) == 1;
      upd_pred_target = ($urandom_range(0, 1) == 1) ? upd_target : $urandom;
      tick();
    end
    idle();
    rst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
